// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared state encoding, byte width and sizing helper for the UART TX arbiter.
package uart_arb_pkg;
  localparam int BYTE_W = 8;
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_HI, WAIT_LO} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin pick; first set request at or after start, wrapping N-1 -> 0.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] idx
);
  logic [IW:0] s;
  always_comb begin
    idx = '0;
    s = '0;
    // Walk farthest-first so the candidate closest to start wins last.
    for (int i = N - 1; i >= 0; i--) begin
      s = {1'b0, start} + (IW+1)'(i);
      s = (s >= (IW+1)'(N)) ? s - (IW+1)'(N) : s;
      if (req[s[IW-1:0]]) idx = s[IW-1:0];
    end
    found = |req;
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin byte arbiter with packet lock feeding a single async UART transmitter.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N            = 4,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        req_valid,
  input  logic [BYTE_W*N-1:0] req_data,
  input  logic [N-1:0]        req_last,
  output logic [N-1:0]        req_ready,
  output logic                tx_start,
  output logic [BYTE_W-1:0]   tx_data,
  input  logic                tx_busy,
  output logic [2:0]          grant_id,
  output logic                locked,
  output logic                err_nostart
);
  localparam int IW = clog2(N);
  localparam int LW = clog2(LOCK_TIMEOUT + 1);
  localparam int BW = clog2(BUSY_TIMEOUT + 1);
  state_t state, state_nx;
  logic [IW-1:0] gid, start, pick, g;
  logic [LW-1:0] lock_cnt;
  logic [BW-1:0] busy_cnt;
  logic [BYTE_W-1:0] bytes [N];
  logic found, cand, accept, lock_run, lock_exp, busy_exp;
  always_comb
    for (int i = 0; i < N; i++) bytes[i] = req_data[BYTE_W*i +: BYTE_W];
  assign start = (gid == IW'(N-1)) ? '0 : gid + 1'b1;
  rr_pick #(.N(N), .IW(IW)) u_pick (.req(req_valid), .start(start), .found(found), .idx(pick));
  assign g         = locked ? gid : pick;
  assign cand      = locked ? req_valid[gid] : found;
  assign accept    = (state == IDLE) && !tx_busy && cand;
  assign req_ready = accept ? (N'(1) << g) : '0;
  assign tx_start  = (state == LAUNCH);
  assign grant_id  = 3'(gid);
  assign lock_run  = locked && (state == IDLE) && !req_valid[gid];
  assign lock_exp  = lock_run && (lock_cnt == LW'(LOCK_TIMEOUT-1));
  assign busy_exp  = (state == WAIT_HI) && !tx_busy && (busy_cnt == BW'(BUSY_TIMEOUT-1));
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = accept ? LAUNCH : IDLE;
      LAUNCH:  state_nx = WAIT_HI;
      WAIT_HI: state_nx = tx_busy ? WAIT_LO : (busy_exp ? IDLE : WAIT_HI);
      WAIT_LO: state_nx = tx_busy ? WAIT_LO : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      tx_data     <= '0;
      gid         <= IW'(N-1);
      locked      <= 1'b0;
      err_nostart <= 1'b0;
      lock_cnt    <= '0;
      busy_cnt    <= '0;
    end else begin
      state    <= state_nx;
      busy_cnt <= (state == WAIT_HI && state_nx == WAIT_HI) ? busy_cnt + 1'b1 : '0;
      if (accept) begin
        tx_data  <= bytes[g];
        gid      <= g;
        locked   <= ~req_last[g];
        lock_cnt <= '0;
      end else if (busy_exp) begin
        locked <= 1'b0;
      end else if (lock_run) begin
        lock_cnt <= lock_cnt + 1'b1;
        locked   <= ~lock_exp;
      end
      if (busy_exp) err_nostart <= 1'b1;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench with a UART busy model and a queue-based arbitration model.
module tb_uart_tx_arbiter;
  localparam int N = 4, LT = 4096, BT = 16;
  logic clk = 0, rst = 1;
  logic [N-1:0] req_valid, req_last, req_ready;
  logic [8*N-1:0] req_data;
  logic tx_start, tx_busy = 0, locked, err_nostart;
  logic [7:0] tx_data;
  logic [2:0] grant_id;
  logic v [N];
  logic [7:0] d [N];
  logic l [N];
  bit uart_en = 1;
  int ucnt = 0, checks = 0, failures = 0, sent_cnt = 0, start_cnt = 0;
  logic [7:0] exp_q [$];
  int gseq [$];
  int m_last = N-1, m_owner = 0, m_idle = 0, age = 0;
  bit m_locked = 0, inflight = 0, seen_busy = 0, cur_ok = 0, prev_acc = 0, prev_busy = 0;
  logic [7:0] cur_exp;

  uart_tx_arbiter #(.N(N), .LOCK_TIMEOUT(LT), .BUSY_TIMEOUT(BT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .grant_id(grant_id), .locked(locked), .err_nostart(err_nostart));

  always #5 clk = ~clk;
  always_comb
    for (int i = 0; i < N; i++) begin
      req_valid[i] = v[i];
      req_data[8*i +: 8] = d[i];
      req_last[i] = l[i];
    end

  // UART transmitter stand-in: busy rises the edge after tx_start and stays up for one frame.
  always @(posedge clk) begin
    if (tx_busy) begin
      if (ucnt <= 1) tx_busy <= 0;
      ucnt <= ucnt - 1;
    end else if (tx_start && uart_en) begin
      tx_busy <= 1;
      ucnt <= $urandom_range(6, 12);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Monitor and reference model: predicts each grant from the spec's RR/lock rules.
  always @(negedge clk) begin
    int w, a;
    if (rst) begin
      m_last = N-1; m_locked = 0; m_idle = 0; inflight = 0; cur_ok = 0; prev_acc = 0;
      prev_busy = tx_busy;
    end else begin
      if (inflight) begin
        age++;
        if (tx_busy) seen_busy = 1;
        if (seen_busy && !tx_busy) inflight = 0;
        else if (!seen_busy && age >= BT + 2) begin inflight = 0; m_locked = 0; end
      end
      if (m_locked && !inflight && !v[m_owner]) begin
        m_idle++;
        if (m_idle >= LT) m_locked = 0;
      end
      if (req_ready != '0) begin
        a = -1;
        for (int i = 0; i < N; i++) if (req_ready[i]) a = i;
        w = m_locked ? m_owner : -1;
        if (!m_locked)
          for (int j = 1; j <= N; j++)
            if (w < 0 && v[(m_last + j) % N]) w = (m_last + j) % N;
        chk("grant_onehot", $countones(req_ready), 1);
        chk("grant_who", a, w);
        chk("accept_when_idle", {tx_busy, inflight}, 0);
        if (w < 0) w = a;
        exp_q.push_back(d[w]);
        gseq.push_back(a);
        m_last = w; m_owner = w; m_locked = !l[w]; m_idle = 0;
        inflight = 1; seen_busy = 0; age = 0;
      end
      if (tx_start) begin
        start_cnt++;
        chk("start_after_accept", prev_acc, 1);
        chk("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          cur_exp = exp_q.pop_front();
          cur_ok = 1;
          chk("tx_data", tx_data, cur_exp);
        end
      end
      if (prev_busy && !tx_busy && cur_ok) begin
        chk("tx_data_hold", tx_data, cur_exp);
        cur_ok = 0;
      end
      prev_acc = (req_ready != '0);
      prev_busy = tx_busy;
    end
  end

  task automatic send(input int i, input logic [7:0] b, input logic la);
    int k;
    d[i] = b; l[i] = la; v[i] = 1;
    k = 0;
    do begin @(negedge clk); k++; end while (!req_ready[i] && k < 20000);
    if (!req_ready[i]) begin
      checks++; failures++;
      $display("FAIL send_timeout: req %0d byte %0h got no req_ready", i, b);
    end else sent_cnt++;
    @(posedge clk); #1;
    v[i] = 0;
  endtask

  task automatic wait_quiet();
    int q, k;
    q = 0; k = 0;
    while (q < 4 && k < 500) begin
      @(negedge clk); k++;
      q = (tx_busy || tx_start) ? 0 : q + 1;
    end
    chk("quiet", q >= 4, 1);
    @(posedge clk); #1;
  endtask

  task automatic drive_rand(input int id);
    for (int k = 0; k < 12; k++) begin
      send(id, 8'($urandom), (k == 11) || ($urandom_range(0, 2) == 0));
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int exp3 [8] = '{1, 2, 3, 0, 1, 2, 3, 0};
    int exp4 [4] = '{1, 1, 1, 2};
    int k, n;
    for (int i = 0; i < N; i++) begin v[i] = 0; d[i] = 0; l[i] = 0; end
    repeat (3) @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_start", tx_start, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_gid", grant_id, N-1);
    chk("rst_locked", locked, 0);
    chk("rst_err", err_nostart, 0);
    @(posedge clk); #1 rst = 0;

    send(0, 8'h55, 1);
    chk("single_start", tx_start, 1);
    chk("single_data", tx_data, 8'h55);
    chk("single_locked", locked, 0);
    chk("single_gid", grant_id, 0);
    wait_quiet();

    gseq.delete();
    fork
      begin send(0, 8'hA0, 1); send(0, 8'hB0, 1); end
      begin send(1, 8'hA1, 1); send(1, 8'hB1, 1); end
      begin send(2, 8'hA2, 1); send(2, 8'hB2, 1); end
      begin send(3, 8'hA3, 1); send(3, 8'hB3, 1); end
    join
    wait_quiet();
    chk("rr_count", gseq.size(), 8);
    for (int i = 0; i < 8 && i < gseq.size(); i++) chk("rr_order", gseq[i], exp3[i]);

    gseq.delete();
    fork
      begin send(1, 8'h10, 0); send(1, 8'h11, 0); send(1, 8'h12, 1); end
      send(2, 8'h20, 1);
    join
    wait_quiet();
    chk("lock_count", gseq.size(), 4);
    for (int i = 0; i < 4 && i < gseq.size(); i++) chk("lock_order", gseq[i], exp4[i]);

    gseq.delete();
    send(1, 8'h30, 0);
    chk("lock_set", locked, 1);
    fork
      send(2, 8'h40, 1);
      begin
        k = 0;
        while (!tx_busy && k < 100) begin @(negedge clk); k++; end
        while (tx_busy && k < 200) begin @(negedge clk); k++; end
        n = 0;
        while (locked && n < 5000) begin @(negedge clk); n++; end
        chk_rng("lock_timeout", n, LT, LT + 4);
      end
    join
    wait_quiet();
    chk("timeout_order_n", gseq.size(), 2);
    if (gseq.size() == 2) chk("timeout_next", gseq[1], 2);

    uart_en = 0;
    send(3, 8'h77, 1);
    repeat (17) @(negedge clk);
    chk("err_before", err_nostart, 0);
    @(negedge clk);
    chk("err_set", err_nostart, 1);
    chk("err_unlock", locked, 0);
    uart_en = 1;
    @(posedge clk); #1;
    send(0, 8'h78, 1);
    wait_quiet();
    chk("err_sticky", err_nostart, 1);

    send(1, 8'h5A, 0);
    k = 0;
    while (!tx_busy && k < 100) begin @(negedge clk); k++; end
    @(negedge clk);
    rst = 1;
    #1;
    chk("mid_rst_ready", req_ready, 0);
    chk("mid_rst_start", tx_start, 0);
    chk("mid_rst_data", tx_data, 0);
    chk("mid_rst_gid", grant_id, N-1);
    chk("mid_rst_locked", locked, 0);
    chk("mid_rst_err", err_nostart, 0);
    @(posedge clk); @(posedge clk); #1 rst = 0;
    send(2, 8'h66, 1);
    chk("post_rst_gid", grant_id, 2);
    wait_quiet();

    fork
      drive_rand(0);
      drive_rand(1);
      drive_rand(2);
      drive_rand(3);
    join
    wait_quiet();
    repeat (20) @(negedge clk);
    chk("sb_empty", exp_q.size(), 0);
    chk("byte_count", start_cnt, sent_cnt);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
